// File: rtl/mux_stream_arb.sv
// mux_stream_arb: N-channel valid/ready stream multiplexer with packet locking.
// The channel is chosen by the external select (MODE 0) or by a round-robin
// arbiter over valid channels (MODE 1). The grant is held until the last
// beat of the packet is accepted. Beats pass through a one-entry registered
// output stage that sustains 1 beat/cycle.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_data/in_valid/   N_IN input streams; channel k data at [k*WIDTH +: WIDTH]
//   in_last/in_ready
//   sel                 requested channel (MODE 0), sampled while idle
//   out_data/out_valid/ registered output stream, out_chan = source channel
//   out_last/out_chan/out_ready
//   busy                high while a packet holds the grant
module mux_stream_arb #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN),
  parameter int MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN-1:0]       in_last,
  output logic [N_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_chan,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state, state_nx;
  logic [SEL_W-1:0] g, g_nx;
  logic [SEL_W-1:0] rr, rr_nx;
  logic             pick_ok;
  logic [SEL_W-1:0] pick;
  logic             slot_free;
  logic             acc;
  logic [WIDTH-1:0] g_data;
  logic             g_valid;
  logic             g_last;

  // Channel selection while idle.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    if (MODE == 0) begin
      // An out-of-range sel matches no channel, so the arbiter stays idle.
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (SEL_W'(k) == sel && in_valid[k]) begin
          pick_ok = 1'b1;
          pick    = SEL_W'(k);
        end
      end
    end else begin
      // Scan offsets from N_IN down to 1 so the last hit written is the
      // closest channel after rr; offset N_IN (rr itself) ranks lowest.
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (in_valid[(32'(rr) + N_IN - i) % N_IN]) begin
          pick_ok = 1'b1;
          pick    = SEL_W'((32'(rr) + N_IN - i) % N_IN);
        end
      end
    end
  end

  // Granted-channel view.
  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (SEL_W'(k) == g) begin
        g_data  = in_data[k*WIDTH +: WIDTH];
        g_valid = in_valid[k];
        g_last  = in_last[k];
      end
    end
  end

  // in_ready depends only on registered state, out_valid and out_ready.
  assign slot_free = !out_valid || out_ready;
  assign acc       = (state == LOCKED) && g_valid && slot_free;
  assign busy      = (state == LOCKED);

  always_comb begin
    in_ready = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      in_ready[k] = (state == LOCKED) && (SEL_W'(k) == g) && slot_free;
    end
  end

  always_comb begin
    state_nx = state;
    g_nx     = g;
    rr_nx    = rr;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nx = LOCKED;
          g_nx     = pick;
        end
      end
      LOCKED: begin
        if (acc && g_last) begin
          state_nx = IDLE;
          rr_nx    = g;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      g         <= '0;
      rr        <= SEL_W'(N_IN - 1);
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else begin
      state <= state_nx;
      g     <= g_nx;
      rr    <= rr_nx;
      if (acc) begin
        out_data  <= g_data;
        out_last  <= g_last;
        out_chan  <= g;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_stream_arb.sv
// Testbench for mux_stream_arb: MODE0 (N_IN=4), MODE1 (N_IN=4) and an
// N_IN=5 MODE0 instance so an out-of-range select value is representable.
module tb_mux_stream_arb;

  logic clk;
  logic rst_n;

  // Instance A: MODE 0, N_IN 4
  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_last, a_in_ready;
  logic [1:0]  a_sel, a_out_chan;
  logic [7:0]  a_out_data;
  logic        a_out_valid, a_out_last, a_out_ready, a_busy;

  // Instance B: MODE 1, N_IN 4
  logic [31:0] b_in_data;
  logic [3:0]  b_in_valid, b_in_last, b_in_ready;
  logic [1:0]  b_sel, b_out_chan;
  logic [7:0]  b_out_data;
  logic        b_out_valid, b_out_last, b_out_ready, b_busy;

  // Instance C: MODE 0, N_IN 5
  logic [39:0] c_in_data;
  logic [4:0]  c_in_valid, c_in_last, c_in_ready;
  logic [2:0]  c_sel, c_out_chan;
  logic [7:0]  c_out_data;
  logic        c_out_valid, c_out_last, c_out_ready, c_busy;

  int n_chk  = 0;
  int n_pass = 0;

  // {chan, last, data}
  logic [10:0] qa[$];
  logic [10:0] qb[$];

  mux_stream_arb #(.WIDTH(8), .N_IN(4), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
    .sel(a_sel),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_last(a_out_last),
    .out_chan(a_out_chan), .out_ready(a_out_ready), .busy(a_busy)
  );

  mux_stream_arb #(.WIDTH(8), .N_IN(4), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
    .sel(b_sel),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last),
    .out_chan(b_out_chan), .out_ready(b_out_ready), .busy(b_busy)
  );

  mux_stream_arb #(.WIDTH(8), .N_IN(5), .MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_data(c_in_data), .in_valid(c_in_valid), .in_last(c_in_last), .in_ready(c_in_ready),
    .sel(c_sel),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_last(c_out_last),
    .out_chan(c_out_chan), .out_ready(c_out_ready), .busy(c_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboards: pop on every output transfer (valid & ready at the next edge).
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) chk("a_sb_extra", 32'({a_out_chan, a_out_last, a_out_data}), 32'h7ff);
      else chk("a_sb", 32'({a_out_chan, a_out_last, a_out_data}), 32'(qa.pop_front()));
    end
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_sb_extra", 32'({b_out_chan, b_out_last, b_out_data}), 32'h7ff);
      else chk("b_sb", 32'({b_out_chan, b_out_last, b_out_data}), 32'(qb.pop_front()));
    end
  end

  // Present one beat, wait for its handshake, then check the 1-cycle latency.
  task automatic send_a(input int ch, input logic [7:0] data, input logic last, output int waited);
    bit ok;
    a_in_data[ch*8 +: 8] = data;
    a_in_last[ch]        = last;
    a_in_valid[ch]       = 1'b1;
    qa.push_back({2'(ch), last, data});
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (a_in_ready[ch]) ok = 1'b1;
      else waited++;
    end
    @(posedge clk);
    #1;
    a_in_valid[ch] = 1'b0;
    chk("a_handshake", 32'(ok), 1);
    if (ok) chk("a_latency", 32'({a_out_valid, a_out_data}), 32'({1'b1, data}));
  endtask

  task automatic send_b(input int ch, input logic [7:0] data, input logic last, output int waited);
    bit ok;
    b_in_data[ch*8 +: 8] = data;
    b_in_last[ch]        = last;
    b_in_valid[ch]       = 1'b1;
    qb.push_back({2'(ch), last, data});
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (b_in_ready[ch]) ok = 1'b1;
      else waited++;
    end
    @(posedge clk);
    #1;
    b_in_valid[ch] = 1'b0;
    chk("b_handshake", 32'(ok), 1);
    if (ok) chk("b_latency", 32'({b_out_valid, b_out_data}), 32'({1'b1, data}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0;
    a_in_data = '0; a_in_valid = '0; a_in_last = '0; a_sel = '0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = '0; b_in_last = '0; b_sel = '0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_valid = '0; c_in_last = '0; c_sel = '0; c_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("a_reset", 32'({a_out_data, a_out_valid, a_out_last, a_out_chan, a_in_ready, a_busy}), 0);
    chk("b_reset", 32'({b_out_data, b_out_valid, b_out_last, b_out_chan, b_in_ready, b_busy}), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MODE0: 3-beat packet on ch2
    a_sel = 2'd2;
    send_a(2, 8'h11, 1'b0, w);
    chk("a_arb_cycle", 32'(w), 1);
    send_a(2, 8'h22, 1'b0, w);
    chk("a_b2b_1", 32'(w), 0);
    send_a(2, 8'h33, 1'b1, w);
    chk("a_b2b_2", 32'(w), 0);
    chk("a_busy_end", 32'(a_busy), 0);
    repeat (2) @(posedge clk);
    #1;

    // MODE0 backpressure on ch1
    a_sel = 2'd1;
    send_a(1, 8'hA5, 1'b0, w);
    a_out_ready     = 1'b0;
    a_in_data[15:8] = 8'h5A;
    a_in_last[1]    = 1'b1;
    a_in_valid[1]   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", 32'({a_out_valid, a_out_data, a_in_ready}), 32'({1'b1, 8'hA5, 4'b0000}));
      @(posedge clk);
      #1;
    end
    a_out_ready = 1'b1;
    send_a(1, 8'h5A, 1'b1, w);
    chk("bp_same_cycle", 32'(w), 0);
    repeat (3) @(posedge clk);
    #1;

    // MODE0, N_IN=5: sel=5 is out of range
    c_sel      = 3'd5;
    c_in_last  = '1;
    c_in_valid = '1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("inv_sel", 32'({c_in_ready, c_out_valid, c_busy}), 0);
    end
    @(posedge clk);
    #1;
    c_in_valid = '0;

    // MODE1: all channels valid with 1-beat packets, data = channel index
    b_in_data  = {8'd3, 8'd2, 8'd1, 8'd0};
    b_in_last  = 4'hF;
    b_in_valid = 4'hF;
    for (int j = 0; j < 8; j++) qb.push_back({2'(j % 4), 1'b1, 8'(j % 4)});
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("rr_ready", 32'(b_in_ready), (k % 2) ? (1 << ((k / 2) % 4)) : 0);
      chk("rr_busy", 32'(b_busy), k % 2);
    end
    @(posedge clk);
    #1;
    b_in_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    // MODE1 fairness: after ch3 was served, only ch1 and ch3 request
    b_in_data[15:8]  = 8'hC1;
    b_in_data[31:24] = 8'hC3;
    b_in_valid       = 4'b1010;
    qb.push_back({2'd1, 1'b1, 8'hC1});
    qb.push_back({2'd3, 1'b1, 8'hC3});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fair_ready", 32'(b_in_ready), (k == 1) ? 32'h2 : (k == 3) ? 32'h8 : 0);
    end
    @(posedge clk);
    #1;
    b_in_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-packet: serve ch0 first so only a reset puts ch0 ahead of ch1
    send_b(0, 8'hE0, 1'b1, w);
    repeat (2) @(posedge clk);
    #1;
    send_b(2, 8'h21, 1'b0, w);
    send_b(2, 8'h22, 1'b0, w);
    rst_n            = 1'b0;
    b_in_data[23:16] = 8'h23;
    b_in_last[2]     = 1'b0;
    b_in_data[7:0]   = 8'hD0;
    b_in_data[15:8]  = 8'hD1;
    b_in_last[1:0]   = 2'b11;
    b_in_valid       = 4'b0111;
    @(posedge clk);
    #1;
    chk("mid_reset", 32'({b_out_data, b_out_valid, b_out_last, b_out_chan, b_in_ready, b_busy}), 0);
    rst_n      = 1'b1;
    b_in_valid = 4'b0011;
    qb.push_back({2'd0, 1'b1, 8'hD0});
    qb.push_back({2'd1, 1'b1, 8'hD1});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_reset_ready", 32'(b_in_ready), (k == 1) ? 32'h1 : (k == 3) ? 32'h2 : 0);
    end
    @(posedge clk);
    #1;
    b_in_valid = '0;
    repeat (3) @(posedge clk);
    #1;

    chk("a_sb_empty", 32'(qa.size()), 0);
    chk("b_sb_empty", 32'(qb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_stream_arb.md
Name: mux_stream_arb

Overview:
- Parametrised N-channel streaming multiplexer. Successor to the combinational 4-in/8-bit bit-sliced muxes.
- Selects one of N_IN valid/ready input streams and forwards it packet-by-packet through a registered output stage.
- Channel choice is either the external select or an internal round-robin arbiter.
- Used in Encaps to merge coefficient streams (sample, poly-mult, pack) onto one shared datapath.

Parameters:
- WIDTH, 8, data bits per beat
- N_IN, 4, number of input channels (>=2)
- SEL_W, $clog2(N_IN), select/channel-index width (derived; do not override)
- MODE, 0, 0 = external select via sel; 1 = round-robin among valid channels

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_data  in  N_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  in  N_IN  per-channel beat valid
- in_last  in  N_IN  per-channel last beat of packet
- in_ready  out  N_IN  per-channel accept
- sel  in  SEL_W  requested channel (MODE 0 only), sampled in IDLE
- out_data  out  WIDTH  registered output beat
- out_valid  out  1  output beat valid
- out_last  out  1  output beat is last of packet
- out_chan  out  SEL_W  channel index of current out_data
- out_ready  in  1  downstream accept
- busy  out  1  high while a packet is locked (state LOCKED)

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - out_data=0, out_valid=0, out_last=0, out_chan=0, in_ready=0, busy=0.
  - State=IDLE; round-robin pointer rr=N_IN-1, so channel 0 has first priority.
- Reset mid-packet: the packet is abandoned and the output register is cleared. No beat is replayed after reset.
- State IDLE (in_ready all 0):
  - MODE 0: if sel<N_IN and in_valid[sel]=1, set grant g=sel and go to LOCKED next cycle.
  - MODE 0: if sel>=N_IN or that channel is not valid, stay in IDLE.
  - MODE 1: g = first k with in_valid[k]=1, searching rr+1, rr+2, ... modulo N_IN. Go to LOCKED; if none is valid, stay in IDLE.
  - Arbitration costs exactly 1 cycle. No beat transfers in IDLE.
- State LOCKED (busy=1):
  - in_ready[g] = (!out_valid | out_ready); in_ready[k≠g]=0.
  - Accept on in_valid[g] & in_ready[g]. At the next edge: out_data=in_data[g], out_last=in_last[g], out_chan=g, out_valid=1.
  - If accepted beat has in_last[g]=1: go to IDLE at the same edge and set rr=g.
  - sel changes and other channels' valids are ignored while LOCKED.
- Output register (one-entry pipeline stage):
  - If out_valid & out_ready and no new accept in the same cycle: out_valid=0 next edge.
  - If out_valid & out_ready with a simultaneous accept: the register reloads and out_valid stays 1 (full throughput, 1 beat/cycle).
  - If out_valid & !out_ready: out_data, out_last and out_chan hold stable; in_ready[g]=0.
- Latency: input handshake to out_valid = 1 cycle.
  - Packet gap: at least 1 idle cycle between the last beat of one packet and the first of the next (arbitration).
  - A 1-beat packet (valid & last on the first beat) is legal: LOCKED for 1 cycle only.
- A grant is never revoked until the last beat is accepted. in_valid[g] dropping mid-packet only stalls.
- No combinational path from in_data to out_data; in_ready depends only on out_valid, out_ready and registered state.

Test Plan:
- MODE0, WIDTH=8, N_IN=4; sel=2; ch2 sends 0x11, 0x22, 0x33(last); out_ready=1. Required: out_data 0x11/0x22/0x33 on consecutive cycles, each 1 cycle after its handshake; out_chan=2; out_last only on 0x33; busy drops after the last accept.
- MODE0; sel=5 (invalid) with all channels valid. Required: stays IDLE, in_ready=0000, out_valid=0 for 10 cycles.
- Backpressure: LOCKED on ch1; out_ready held 0 for 3 cycles with out_valid=1 (0xA5). Required: out_data holds 0xA5, in_ready[1]=0; on out_ready=1 the next beat is accepted the same cycle and out_valid stays 1.
- MODE1: all 4 channels continuously valid with 1-beat packets (last=1), data=channel index. Required: grant order 0,1,2,3,0,...; out_chan matches data; one IDLE cycle between grants.
- MODE1 fairness: only ch3 and ch1 valid after ch3 served. Required: next grant is ch1, then ch3.
- Reset mid-packet: rst_n=0 for 1 cycle after the 2nd beat of a 4-beat packet. Required: next edge out_valid=0, busy=0, in_ready=0000, out_data=0; channel 0 has priority afterwards (MODE1).
